// File: rtl/csr_access_sequencer.sv
// Zicsr read-then-write sequencer for a single-port CSR file, arbitrating
// between the core pipeline (id 0) and the debug port (id 1, fixed priority).
module csr_access_sequencer #(
   parameter int unsigned C_XLEN = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              clk_en_i,

   input  logic              core_req_valid_i,
   output logic              core_req_ready_o,
   input  logic [11:0]       core_req_addr_i,
   input  logic [1:0]        core_req_op_i,
   input  logic [C_XLEN-1:0] core_req_src_i,
   input  logic              core_req_nowr_i,

   input  logic              dbg_req_valid_i,
   output logic              dbg_req_ready_o,
   input  logic [11:0]       dbg_req_addr_i,
   input  logic [1:0]        dbg_req_op_i,
   input  logic [C_XLEN-1:0] dbg_req_src_i,
   input  logic              dbg_req_nowr_i,

   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_id_o,
   output logic [C_XLEN-1:0] rsp_data_o,
   output logic              rsp_err_o,

   output logic [11:0]       csr_addr_o,
   input  logic [C_XLEN-1:0] csr_rdata_i,
   input  logic              csr_illegal_i,
   output logic              csr_access_o,
   output logic [C_XLEN-1:0] csr_wdata_o
);

   localparam int unsigned AW = 12;
   localparam logic [1:0] OP_RSV = 2'b00;
   localparam logic [1:0] OP_RW  = 2'b01;
   localparam logic [1:0] OP_RS  = 2'b10;
   localparam logic [1:0] OP_RC  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_RESP  = 2'b11
   } state_e;

   state_e            state_q;
   logic [AW-1:0]     addr_q;
   logic [1:0]        op_q;
   logic [C_XLEN-1:0] src_q;
   logic              nowr_q;
   logic              id_q;
   logic [C_XLEN-1:0] old_q;
   logic              access_q;
   logic [C_XLEN-1:0] wdata_q;
   logic              rsp_valid_q;
   logic              rsp_id_q;
   logic [C_XLEN-1:0] rsp_data_q;
   logic              rsp_err_q;

   logic              err_d;
   logic [C_XLEN-1:0] wdata_d;
   logic              idle_en;

   // Request acceptance is only possible in an enabled IDLE cycle; debug wins.
   assign idle_en          = clk_en_i & (state_q == ST_IDLE);
   assign dbg_req_ready_o  = idle_en & dbg_req_valid_i;
   assign core_req_ready_o = idle_en & core_req_valid_i & ~dbg_req_valid_i;

   assign csr_addr_o   = addr_q;
   assign csr_access_o = access_q & clk_en_i;
   assign csr_wdata_o  = wdata_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = rsp_id_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_err_o    = rsp_err_q;

   // Error and write-data derivation from the READ-cycle read data.
   always_comb begin
      err_d   = csr_illegal_i | (op_q == OP_RSV);
      wdata_d = '0;
      case (op_q)
         OP_RW:   wdata_d = src_q;
         OP_RS:   wdata_d = csr_rdata_i | src_q;
         OP_RC:   wdata_d = csr_rdata_i & ~src_q;
         default: wdata_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         op_q        <= '0;
         src_q       <= '0;
         nowr_q      <= 1'b0;
         id_q        <= 1'b0;
         old_q       <= '0;
         access_q    <= 1'b0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else if (clk_en_i) begin
         case (state_q)
            ST_IDLE: begin
               if (dbg_req_valid_i) begin
                  addr_q  <= dbg_req_addr_i;
                  op_q    <= dbg_req_op_i;
                  src_q   <= dbg_req_src_i;
                  nowr_q  <= dbg_req_nowr_i;
                  id_q    <= 1'b1;
                  state_q <= ST_READ;
               end else if (core_req_valid_i) begin
                  addr_q  <= core_req_addr_i;
                  op_q    <= core_req_op_i;
                  src_q   <= core_req_src_i;
                  nowr_q  <= core_req_nowr_i;
                  id_q    <= 1'b0;
                  state_q <= ST_READ;
               end
            end
            ST_READ: begin
               old_q <= csr_rdata_i;
               // Errors and suppressed writes skip the write strobe entirely.
               if (err_d || nowr_q) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= id_q;
                  rsp_err_q   <= err_d;
                  rsp_data_q  <= err_d ? '0 : csr_rdata_i;
               end else begin
                  state_q  <= ST_WRITE;
                  access_q <= 1'b1;
                  wdata_q  <= wdata_d;
               end
            end
            ST_WRITE: begin
               access_q    <= 1'b0;
               wdata_q     <= '0;
               state_q     <= ST_RESP;
               rsp_valid_q <= 1'b1;
               rsp_id_q    <= id_q;
               rsp_err_q   <= 1'b0;
               rsp_data_q  <= old_q;
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_id_q    <= 1'b0;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Scoreboard bench for csr_access_sequencer: a behavioural CSR file answers reads,
// expected strobes and responses are queued at request time and popped as they appear.
module tb_csr_access_sequencer;

   localparam logic [11:0] ILL_ADDR = 12'h7FF;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        clk_en_i;
   logic        core_req_valid_i, core_req_ready_o, core_req_nowr_i;
   logic [11:0] core_req_addr_i;
   logic [1:0]  core_req_op_i;
   logic [31:0] core_req_src_i;
   logic        dbg_req_valid_i, dbg_req_ready_o, dbg_req_nowr_i;
   logic [11:0] dbg_req_addr_i;
   logic [1:0]  dbg_req_op_i;
   logic [31:0] dbg_req_src_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o;
   logic [31:0] rsp_data_o;
   logic [11:0] csr_addr_o;
   logic [31:0] csr_rdata_i;
   logic        csr_illegal_i, csr_access_o;
   logic [31:0] csr_wdata_o;

   logic [31:0] mem   [0:4095];
   logic [31:0] model [0:4095];

   typedef struct packed { logic id; logic [31:0] data; logic err; } rsp_t;
   typedef struct packed { logic [11:0] addr; logic [31:0] data; } wr_t;
   rsp_t rq[$];
   wr_t  wq[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int s_cyc, acc_cyc, strobe_cyc, rsp_cyc;
   int strobes = 0;
   logic s_core_rdy, s_dbg_rdy, s_access, s_rsp_valid, s_rsp_id, s_rsp_err;
   logic [31:0] s_rsp_data;

   csr_access_sequencer #(.C_XLEN(32)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
      .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
      .core_req_addr_i(core_req_addr_i), .core_req_op_i(core_req_op_i),
      .core_req_src_i(core_req_src_i), .core_req_nowr_i(core_req_nowr_i),
      .dbg_req_valid_i(dbg_req_valid_i), .dbg_req_ready_o(dbg_req_ready_o),
      .dbg_req_addr_i(dbg_req_addr_i), .dbg_req_op_i(dbg_req_op_i),
      .dbg_req_src_i(dbg_req_src_i), .dbg_req_nowr_i(dbg_req_nowr_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .csr_addr_o(csr_addr_o), .csr_rdata_i(csr_rdata_i), .csr_illegal_i(csr_illegal_i),
      .csr_access_o(csr_access_o), .csr_wdata_o(csr_wdata_o)
   );

   always #5 clk_i = ~clk_i;

   assign csr_rdata_i   = mem[csr_addr_o];
   assign csr_illegal_i = (csr_addr_o == ILL_ADDR);

   function automatic void preload(input logic [11:0] addr, input logic [31:0] val);
      mem[addr]   = val;
      model[addr] = val;
   endfunction

   // Reference behaviour: queue the expected strobe (if any) and response.
   function automatic void expect_req(input logic id, input logic [11:0] addr, input logic [1:0] op,
                                      input logic [31:0] src, input logic nowr);
      logic [31:0] old;
      logic [31:0] wd;
      logic        err;
      rsp_t        r;
      wr_t         w;
      old = model[addr];
      err = (addr == ILL_ADDR) || (op == 2'b00);
      case (op)
         2'b01:   wd = src;
         2'b10:   wd = old | src;
         default: wd = old & ~src;
      endcase
      if (err) begin
         r = '{id: id, data: 32'h0, err: 1'b1};
      end else begin
         if (!nowr) begin
            w = '{addr: addr, data: wd};
            wq.push_back(w);
            model[addr] = wd;
         end
         r = '{id: id, data: old, err: 1'b0};
      end
      rq.push_back(r);
   endfunction

   task automatic set_core(input logic v, input logic [11:0] a, input logic [1:0] op,
                           input logic [31:0] src, input logic nowr);
      core_req_valid_i = v; core_req_addr_i = a; core_req_op_i = op;
      core_req_src_i = src; core_req_nowr_i = nowr;
   endtask

   task automatic set_dbg(input logic v, input logic [11:0] a, input logic [1:0] op,
                          input logic [31:0] src, input logic nowr);
      dbg_req_valid_i = v; dbg_req_addr_i = a; dbg_req_op_i = op;
      dbg_req_src_i = src; dbg_req_nowr_i = nowr;
   endtask

   // One clock: sample at the falling edge, score strobes and responses, advance.
   task automatic step();
      wr_t  w;
      rsp_t r;
      @(negedge clk_i);
      s_cyc = cyc;
      s_core_rdy = core_req_ready_o; s_dbg_rdy = dbg_req_ready_o;
      s_access = csr_access_o; s_rsp_valid = rsp_valid_o;
      s_rsp_id = rsp_id_o; s_rsp_data = rsp_data_o; s_rsp_err = rsp_err_o;
      if (csr_access_o) begin
         strobes++; strobe_cyc = cyc; checks++;
         if (wq.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr=%h data=%h, expected no strobe", csr_addr_o, csr_wdata_o);
         end else begin
            w = wq.pop_front();
            if (csr_addr_o !== w.addr || csr_wdata_o !== w.data) begin
               errors++;
               $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                        csr_addr_o, csr_wdata_o, w.addr, w.data);
            end
         end
         mem[csr_addr_o] = csr_wdata_o;
      end
      if (rsp_valid_o && rsp_ready_i) begin
         rsp_cyc = cyc; checks++;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got id=%0b data=%h err=%0b, expected no response",
                     rsp_id_o, rsp_data_o, rsp_err_o);
         end else begin
            r = rq.pop_front();
            if ({rsp_id_o, rsp_data_o, rsp_err_o} !== {r.id, r.data, r.err}) begin
               errors++;
               $display("FAIL rsp_data: got id=%0b data=%h err=%0b, expected id=%0b data=%h err=%0b",
                        rsp_id_o, rsp_data_o, rsp_err_o, r.id, r.data, r.err);
            end
         end
      end
      @(posedge clk_i); #1;
      cyc++;
   endtask

   task automatic send(input logic id, input logic [11:0] a, input logic [1:0] op,
                       input logic [31:0] src, input logic nowr);
      bit acc = 1'b0;
      expect_req(id, a, op, src, nowr);
      if (id) set_dbg(1'b1, a, op, src, nowr);
      else    set_core(1'b1, a, op, src, nowr);
      for (int i = 0; i < 40 && !acc; i++) begin
         step();
         if (id ? s_dbg_rdy : s_core_rdy) begin acc = 1'b1; acc_cyc = s_cyc; end
      end
      if (id) set_dbg(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
      else    set_core(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
      checks++;
      if (!acc) begin errors++; $display("FAIL send_accept: got no ready in 40 cycles, expected acceptance"); end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin step(); n++; end
      checks++;
      if (rq.size() != 0 || wq.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: got pending rsp=%0d wr=%0d, expected 0 0", name, rq.size(), wq.size());
         rq.delete(); wq.delete();
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({rsp_valid_o, rsp_id_o, rsp_err_o, csr_access_o, core_req_ready_o, dbg_req_ready_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got v=%0b id=%0b err=%0b acc=%0b crdy=%0b drdy=%0b, expected all 0",
                  rsp_valid_o, rsp_id_o, rsp_err_o, csr_access_o, core_req_ready_o, dbg_req_ready_o);
      end
      checks++;
      if (rsp_data_o !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h, expected 0", rsp_data_o); end
      checks++;
      if (csr_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h, expected 0", csr_wdata_o); end
      checks++;
      if (csr_addr_o !== 12'h0) begin errors++; $display("FAIL reset_addr: got %h, expected 0", csr_addr_o); end
   endtask

   task automatic test_rw();
      int s0 = strobes;
      send(1'b0, 12'h340, 2'b01, 32'hDEADBEEF, 1'b0);
      wait_idle("rw");
      checks++;
      if (strobe_cyc != acc_cyc + 2) begin errors++; $display("FAIL rw_strobe_latency: got %0d, expected %0d", strobe_cyc - acc_cyc, 2); end
      checks++;
      if (rsp_cyc != acc_cyc + 3) begin errors++; $display("FAIL rw_rsp_latency: got %0d, expected %0d", rsp_cyc - acc_cyc, 3); end
      checks++;
      if (strobes != s0 + 1) begin errors++; $display("FAIL rw_strobe_count: got %0d, expected 1", strobes - s0); end
      checks++;
      if (mem[12'h340] !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_csr_value: got %h, expected deadbeef", mem[12'h340]); end
   endtask

   task automatic test_set_clear();
      int s0;
      send(1'b0, 12'h300, 2'b10, 32'h000000F0, 1'b0);
      wait_idle("rs");
      checks++;
      if (mem[12'h300] !== 32'hFF) begin errors++; $display("FAIL rs_csr_value: got %h, expected 000000ff", mem[12'h300]); end
      send(1'b0, 12'h300, 2'b11, 32'h0000000F, 1'b0);
      wait_idle("rc");
      checks++;
      if (mem[12'h300] !== 32'hF0) begin errors++; $display("FAIL rc_csr_value: got %h, expected 000000f0", mem[12'h300]); end
      s0 = strobes;
      send(1'b0, 12'h300, 2'b10, 32'h0, 1'b1);
      wait_idle("nowr");
      checks++;
      if (strobes != s0) begin errors++; $display("FAIL nowr_strobe_count: got %0d, expected 0", strobes - s0); end
      checks++;
      if (rsp_cyc != acc_cyc + 2) begin errors++; $display("FAIL nowr_rsp_latency: got %0d, expected 2", rsp_cyc - acc_cyc); end
   endtask

   task automatic test_error();
      int s0 = strobes;
      send(1'b0, ILL_ADDR, 2'b01, 32'h1, 1'b0);
      wait_idle("illegal");
      checks++;
      if (rsp_cyc != acc_cyc + 2) begin errors++; $display("FAIL illegal_rsp_latency: got %0d, expected 2", rsp_cyc - acc_cyc); end
      send(1'b1, 12'h341, 2'b00, 32'hFFFF, 1'b0);
      wait_idle("reserved_op");
      checks++;
      if (strobes != s0) begin errors++; $display("FAIL error_strobe_count: got %0d, expected 0", strobes - s0); end
      checks++;
      if (mem[ILL_ADDR] !== 32'hABCD1234 || mem[12'h341] !== 32'h5555) begin
         errors++;
         $display("FAIL error_csr_value: got %h %h, expected abcd1234 00005555", mem[ILL_ADDR], mem[12'h341]);
      end
   endtask

   task automatic test_priority();
      int n1;
      bit acc = 1'b0;
      expect_req(1'b1, 12'h343, 2'b01, 32'h2, 1'b0);
      expect_req(1'b0, 12'h342, 2'b01, 32'h1, 1'b0);
      set_dbg(1'b1, 12'h343, 2'b01, 32'h2, 1'b0);
      set_core(1'b1, 12'h342, 2'b01, 32'h1, 1'b0);
      step();
      n1 = s_cyc;
      checks++;
      if (s_dbg_rdy !== 1'b1 || s_core_rdy !== 1'b0) begin
         errors++;
         $display("FAIL priority_grant: got dbg_rdy=%0b core_rdy=%0b, expected 1 0", s_dbg_rdy, s_core_rdy);
      end
      set_dbg(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
      for (int i = 0; i < 20 && !acc; i++) begin
         step();
         if (s_core_rdy) begin acc = 1'b1; acc_cyc = s_cyc; end
      end
      set_core(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
      checks++;
      if (!acc || acc_cyc != n1 + 4) begin
         errors++;
         $display("FAIL priority_core_accept: got accepted=%0b after %0d cycles, expected 1 after 4", acc, acc_cyc - n1);
      end
      wait_idle("priority");
   endtask

   task automatic test_backpressure();
      bit seen = 1'b0;
      rsp_ready_i = 1'b0;
      send(1'b0, 12'h344, 2'b01, 32'h55, 1'b0);
      for (int i = 0; i < 10 && !seen; i++) begin step(); seen = s_rsp_valid; end
      checks++;
      if (!seen) begin errors++; $display("FAIL bp_rsp_valid: got no rsp_valid in 10 cycles, expected valid"); end
      expect_req(1'b0, 12'h344, 2'b10, 32'h0, 1'b1);
      set_core(1'b1, 12'h344, 2'b10, 32'h0, 1'b1);
      set_dbg(1'b1, 12'h345, 2'b01, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({s_rsp_valid, s_rsp_id, s_rsp_data, s_rsp_err, s_core_rdy, s_dbg_rdy} !== {1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold: got v=%0b id=%0b data=%h err=%0b crdy=%0b drdy=%0b, expected 1 0 00000077 0 0 0",
                     s_rsp_valid, s_rsp_id, s_rsp_data, s_rsp_err, s_core_rdy, s_dbg_rdy);
         end
      end
      set_dbg(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
      rsp_ready_i = 1'b1;
      step();
      checks++;
      if (s_core_rdy !== 1'b0) begin errors++; $display("FAIL bp_handshake_ready: got %0b, expected 0", s_core_rdy); end
      step();
      checks++;
      if (s_core_rdy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got %0b, expected 1", s_core_rdy); end
      set_core(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
      wait_idle("backpressure");
   endtask

   task automatic test_clk_en();
      int  s0;
      bit  acc = 1'b0;
      clk_en_i = 1'b0;
      expect_req(1'b0, 12'h345, 2'b11, 32'h0C, 1'b0);
      set_core(1'b1, 12'h345, 2'b11, 32'h0C, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (s_core_rdy !== 1'b0) begin errors++; $display("FAIL clken_ready_gate: got %0b, expected 0", s_core_rdy); end
      end
      clk_en_i = 1'b1;
      for (int i = 0; i < 5 && !acc; i++) begin step(); acc = s_core_rdy; end
      set_core(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
      step();
      clk_en_i = 1'b0;
      s0 = strobes;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (s_access !== 1'b0 || s_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL clken_freeze: got access=%0b rsp_valid=%0b, expected 0 0", s_access, s_rsp_valid);
         end
      end
      clk_en_i = 1'b1;
      wait_idle("clk_en");
      checks++;
      if (strobes != s0 + 1 || mem[12'h345] !== 32'h30) begin
         errors++;
         $display("FAIL clken_write: got strobes=%0d csr=%h, expected 1 00000030", strobes - s0, mem[12'h345]);
      end
   endtask

   task automatic test_reset_mid();
      int c0;
      send(1'b0, 12'h346, 2'b01, 32'h99, 1'b0);
      step();
      #1;
      checks++;
      if (csr_access_o !== 1'b1) begin errors++; $display("FAIL midrst_in_write: got access=%0b, expected 1", csr_access_o); end
      reset_i = 1'b1;
      #1;
      checks++;
      if (csr_access_o !== 1'b0 || csr_wdata_o !== 32'h0 || rsp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs: got access=%0b wdata=%h rsp_valid=%0b, expected 0 0 0",
                  csr_access_o, csr_wdata_o, rsp_valid_o);
      end
      rq.delete(); wq.delete();
      model[12'h346] = 32'h12;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (s_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp: got rsp_valid=%0b, expected 0", s_rsp_valid); end
      end
      checks++;
      if (mem[12'h346] !== 32'h12) begin errors++; $display("FAIL midrst_csr_value: got %h, expected 00000012", mem[12'h346]); end
      c0 = cyc;
      send(1'b0, 12'h346, 2'b10, 32'h100, 1'b0);
      checks++;
      if (acc_cyc != c0) begin errors++; $display("FAIL midrst_idle: got accept after %0d cycles, expected 0", acc_cyc - c0); end
      wait_idle("post_reset");
      checks++;
      if (mem[12'h346] !== 32'h112) begin errors++; $display("FAIL midrst_post_write: got %h, expected 00000112", mem[12'h346]); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin mem[i] = 32'h0; model[i] = 32'h0; end
      preload(12'h340, 32'h11);
      preload(12'h300, 32'h0F);
      preload(ILL_ADDR, 32'hABCD1234);
      preload(12'h341, 32'h5555);
      preload(12'h342, 32'h100);
      preload(12'h343, 32'h200);
      preload(12'h344, 32'h77);
      preload(12'h345, 32'h3C);
      preload(12'h346, 32'h12);
      reset_i = 1'b1; clk_en_i = 1'b1; rsp_ready_i = 1'b1;
      set_core(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
      set_dbg(1'b0, 12'h0, 2'b00, 32'h0, 1'b0);
      repeat (3) @(posedge clk_i);
      #1;
      test_reset();
      reset_i = 1'b0;
      test_rw();
      test_set_clear();
      test_error();
      test_priority();
      test_backpressure();
      test_clk_en();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
